led_afterglow: RTL and testbench

- Downstream consumer of the two-eye cylon pattern generator. Drives the 12 front-panel LEDs.
- Adds a decaying "afterglow" trail behind each lit LED using per-LED PWM brightness.
- Offers a raw pass-through mode and two status-display modes, selected by a 2-bit mode input.
- Output is registered and goes straight to the LED pins.

---
 rtl/led_afterglow_if.sv | 26 ++
 rtl/led_afterglow.sv | 79 +++++++
 tb/tb_led_afterglow.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_afterglow_if.sv
// LED panel bus: pattern/status/mode from the cylon side, LED drive and decay strobe back.
interface led_afterglow_if #(
   parameter int MXLED = 12
);
   logic [MXLED-1:0] pat_in;
   logic [MXLED-1:0] status_in;
   logic [1:0]       mode;
   logic [MXLED-1:0] led_out;
   logic             dcy_tick;

   modport master (
      output pat_in,
      output status_in,
      output mode,
      input  led_out,
      input  dcy_tick
   );

   modport slave (
      input  pat_in,
      input  status_in,
      input  mode,
      output led_out,
      output dcy_tick
   );
endinterface

// File: rtl/led_afterglow.sv
// Front-panel LED driver: per-LED decaying PWM trail behind the cylon eyes,
// plus raw and status display modes, registered straight to the pins.
module led_afterglow #(
   parameter int MXLED  = 12,
   parameter int MXLVL  = 4,
   parameter int MXDCY  = 16,
   parameter bit INVERT = 1'b0
) (
   input logic             clock,
   input logic             reset,
   led_afterglow_if.slave  bus
);

   localparam logic [MXLVL-1:0] FULL = '1;

   logic [MXDCY-1:0] dcy_cnt;
   logic [MXLVL-1:0] pwm_cnt;
   logic             dcy_tick;
   logic [MXLVL-1:0] level [MXLED];
   logic [MXLED-1:0] glow;
   logic [MXLED-1:0] mux;
   logic [MXLED-1:0] led_q;

   // The strobe lands on the clock after the prescaler wraps, so levels see it one cycle later.
   always_ff @(posedge clock) begin
      if (reset) begin
         dcy_cnt  <= '0;
         pwm_cnt  <= '0;
         dcy_tick <= 1'b0;
      end else begin
         dcy_cnt  <= dcy_cnt + 1'b1;
         pwm_cnt  <= pwm_cnt + 1'b1;
         dcy_tick <= &dcy_cnt;
      end
   end

   // A lit eye always reloads full brightness, even on a decay clock.
   always_ff @(posedge clock) begin
      for (int i = 0; i < MXLED; i++) begin
         if (reset) begin
            level[i] <= '0;
         end else if (bus.pat_in[i]) begin
            level[i] <= FULL;
         end else if (dcy_tick && (level[i] != '0)) begin
            level[i] <= level[i] - 1'b1;
         end
      end
   end

   always_comb begin
      glow = '0;
      for (int i = 0; i < MXLED; i++) begin
         glow[i] = bus.pat_in[i] | (pwm_cnt < level[i]);
      end
   end

   // Blink phase rides on the prescaler MSB, so entering mode 3 never restarts it.
   always_comb begin
      mux = '0;
      case (bus.mode)
         2'd0:    mux = glow;
         2'd1:    mux = bus.pat_in;
         2'd2:    mux = bus.status_in;
         default: mux = dcy_cnt[MXDCY-1] ? bus.status_in : '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         led_q <= {MXLED{INVERT}};
      end else begin
         led_q <= mux ^ {MXLED{INVERT}};
      end
   end

   assign bus.led_out  = led_q;
   assign bus.dcy_tick = dcy_tick;

endmodule

// File: tb/tb_led_afterglow.sv
// Scoreboard bench: stimulus queues hand-computed expectations by cycle,
// a monitor compares both polarity variants of the DUT as each cycle comes up.
module tb_led_afterglow;

   localparam int MXLED = 12;
   localparam int MXLVL = 4;
   localparam int MXDCY = 6;

   localparam int K_LED  = 0;
   localparam int K_TICK = 1;
   localparam int K_DUTY = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] pat = '0;
   logic [11:0] status = '0;
   logic [1:0]  mode = '0;

   always #5 clock = ~clock;

   led_afterglow_if #(.MXLED(MXLED)) bus0 ();
   led_afterglow_if #(.MXLED(MXLED)) bus1 ();

   assign bus0.pat_in    = pat;
   assign bus0.status_in = status;
   assign bus0.mode      = mode;
   assign bus1.pat_in    = pat;
   assign bus1.status_in = status;
   assign bus1.mode      = mode;

   led_afterglow #(.MXLED(MXLED), .MXLVL(MXLVL), .MXDCY(MXDCY), .INVERT(1'b0)) dut0 (
      .clock (clock),
      .reset (reset),
      .bus   (bus0)
   );

   led_afterglow #(.MXLED(MXLED), .MXLVL(MXLVL), .MXDCY(MXDCY), .INVERT(1'b1)) dut1 (
      .clock (clock),
      .reset (reset),
      .bus   (bus1)
   );

   typedef struct {
      int          cyc;
      string       name;
      int          kind;
      logic [11:0] exp;
      logic [11:0] mask;
      int          bidx;
   } chk_t;

   chk_t        sb[$];
   int          cyc = 0;
   int          rst_cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          mi;
   logic [11:0] h0 [16];
   logic [11:0] h1 [16];

   always @(posedge clock) cyc <= cyc + 1;

   task automatic push(input int t, input string name, input int kind,
                       input logic [11:0] exp, input logic [11:0] mask, input int bidx);
      chk_t c;
      c.cyc  = rst_cyc + t;
      c.name = name;
      c.kind = kind;
      c.exp  = exp;
      c.mask = mask;
      c.bidx = bidx;
      sb.push_back(c);
   endtask

   task automatic report(input string name, input string which, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("[TB] FAIL %s (%s) cycle %0d: got %0h want %0h", name, which, cyc, act, req);
      end
   endtask

   task automatic check_output(input chk_t c);
      int cnt0;
      int cnt1;
      case (c.kind)
         K_LED: begin
            report(c.name, "normal",   int'(bus0.led_out & c.mask),  int'(c.exp & c.mask));
            report(c.name, "inverted", int'(~bus1.led_out & c.mask), int'(c.exp & c.mask));
         end
         K_TICK: begin
            report(c.name, "normal",   int'(bus0.dcy_tick), int'(c.exp[0]));
            report(c.name, "inverted", int'(bus1.dcy_tick), int'(c.exp[0]));
         end
         default: begin
            cnt0 = 0;
            cnt1 = 0;
            for (int k = 0; k < 16; k++) begin
               cnt0 += int'(h0[k][c.bidx]);
               cnt1 += int'(!h1[k][c.bidx]);
            end
            report(c.name, "normal duty",   cnt0, int'(c.exp));
            report(c.name, "inverted duty", cnt1, int'(c.exp));
         end
      endcase
   endtask

   // Monitor: keep 16 cycles of history for duty checks, then retire due entries.
   always @(posedge clock) begin
      #2;
      for (int k = 0; k < 15; k++) begin
         h0[k] = h0[k+1];
         h1[k] = h1[k+1];
      end
      h0[15] = bus0.led_out;
      h1[15] = bus1.led_out;
      mi = 0;
      while (mi < sb.size()) begin
         if (sb[mi].cyc == cyc) begin
            check_output(sb[mi]);
            sb.delete(mi);
         end else if (sb[mi].cyc < cyc) begin
            report(sb[mi].name, "missed", 0, 1);
            sb.delete(mi);
         end else begin
            mi++;
         end
      end
   end

   task automatic wait_t(input int t);
      while (cyc - rst_cyc < t) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Three reset edges with junk inputs; returns just after the last one with inputs idle.
   task automatic apply_stimulus_reset();
      @(posedge clock);
      #1;
      rst_cyc = cyc + 3;
      reset  = 1'b1;
      pat    = 12'hFFF;
      status = 12'hFFF;
      mode   = 2'd1;
      for (int k = -2; k <= 0; k++) begin
         push(k, "reset_led", K_LED, 12'h000, 12'hFFF, 0);
         push(k, "reset_tick", K_TICK, 12'h000, 12'h001, 0);
      end
      repeat (3) @(posedge clock);
      #1;
      reset  = 1'b0;
      pat    = '0;
      status = '0;
      mode   = 2'd0;
   endtask

   logic [11:0] cyl    [10] = '{12'h801, 12'h402, 12'h204, 12'h108, 12'h090,
                               12'h060, 12'h090, 12'h108, 12'h204, 12'h402};
   logic [11:0] cyl_or [10] = '{12'h801, 12'hC03, 12'hE07, 12'hF0F, 12'hF9F,
                               12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};

   initial begin
      // idle after reset, plus prescaler strobe timing
      apply_stimulus_reset();
      for (int t = 1; t <= 200; t++) push(t, "idle_dark", K_LED, 12'h000, 12'hFFF, 0);
      push(63,  "tick_pre",   K_TICK, 12'h000, 12'h001, 0);
      push(64,  "tick_first", K_TICK, 12'h001, 12'h001, 0);
      push(65,  "tick_post",  K_TICK, 12'h000, 12'h001, 0);
      push(128, "tick_second", K_TICK, 12'h001, 12'h001, 0);
      wait_t(210);

      // single pulse trail on LED 0
      apply_stimulus_reset();
      pat = 12'h001;
      push(1, "pulse_on", K_LED, 12'h001, 12'hFFF, 0);
      for (int m = 0; m < 16; m++) push(64*m + 64, "trail_duty", K_DUTY, 12'(15 - m), 12'h001, 0);
      push(100,  "trail_others", K_LED, 12'h000, 12'hFFE, 0);
      push(500,  "trail_others", K_LED, 12'h000, 12'hFFE, 0);
      push(900,  "trail_others", K_LED, 12'h000, 12'hFFE, 0);
      push(1000, "trail_gone",   K_LED, 12'h000, 12'hFFF, 0);
      wait_t(1);
      pat = 12'h000;
      wait_t(1030);

      // reload vs decay on LED 5, then a hold across five ticks
      apply_stimulus_reset();
      pat = 12'h020;
      push(832, "decay_l3",     K_DUTY, 12'd3,  12'h020, 5);
      push(880, "reload_pulse", K_DUTY, 12'd15, 12'h020, 5);
      for (int t = 901; t <= 1220; t++) push(t, "hold_on", K_LED, 12'h020, 12'h020, 0);
      push(1264, "hold_duty", K_DUTY, 12'd15, 12'h020, 5);
      wait_t(1);
      pat = 12'h000;
      wait_t(832);
      pat = 12'h020;
      wait_t(833);
      pat = 12'h000;
      wait_t(900);
      pat = 12'h020;
      wait_t(1220);
      pat = 12'h000;
      wait_t(1270);

      // display modes
      apply_stimulus_reset();
      status = 12'hA5A;
      pat    = 12'h402;
      mode   = 2'd1;
      push(1,  "mode1_raw",    K_LED, 12'h402, 12'hFFF, 0);
      push(2,  "mode2_status", K_LED, 12'hA5A, 12'hFFF, 0);
      push(3,  "blink_off",    K_LED, 12'h000, 12'hFFF, 0);
      push(32, "blink_off",    K_LED, 12'h000, 12'hFFF, 0);
      push(33, "blink_on",     K_LED, 12'hA5A, 12'hFFF, 0);
      push(64, "blink_on",     K_LED, 12'hA5A, 12'hFFF, 0);
      push(65, "blink_off",    K_LED, 12'h000, 12'hFFF, 0);
      push(96, "blink_off",    K_LED, 12'h000, 12'hFFF, 0);
      push(97, "blink_on",     K_LED, 12'hA5A, 12'hFFF, 0);
      push(101, "mode0_glow",  K_LED, 12'h402, 12'hFFF, 0);
      wait_t(1);
      mode = 2'd2;
      wait_t(2);
      mode = 2'd3;
      wait_t(100);
      mode = 2'd0;
      wait_t(105);

      // mode round trip: trail keeps decaying while status is shown
      apply_stimulus_reset();
      pat = 12'h001;
      push(5,   "rst_clears", K_LED,  12'h001, 12'hFFF, 0);
      push(100, "rt_status",  K_LED,  12'h000, 12'hFFF, 0);
      push(240, "rt_duty",    K_DUTY, 12'd12,  12'h001, 0);
      wait_t(1);
      pat = 12'h000;
      wait_t(10);
      mode = 2'd2;
      wait_t(200);
      mode = 2'd0;
      wait_t(245);

      // cylon steps, raw mode
      apply_stimulus_reset();
      mode = 2'd1;
      for (int k = 0; k < 10; k++) begin
         wait_t(k);
         pat = cyl[k];
         push(k + 1, "cylon_raw", K_LED, cyl[k], 12'hFFF, 0);
      end
      wait_t(10);
      pat = 12'h000;
      wait_t(12);

      // cylon steps, afterglow accumulates the eyes
      apply_stimulus_reset();
      for (int k = 0; k < 10; k++) begin
         wait_t(k);
         pat = cyl[k];
         push(k + 1, "cylon_glow", K_LED, cyl_or[k], 12'hFFF, 0);
      end
      wait_t(10);
      pat = 12'h000;
      wait_t(14);

      repeat (3) @(posedge clock);
      #3;
      while (sb.size() > 0) begin
         report(sb[0].name, "never checked", 0, 1);
         void'(sb.pop_front());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
